// File: rtl/param_chunk_adder_if.sv
// Handshake and operand/result bundle for param_chunk_adder.
// Optional macro PARAM_CHUNK_ADDER_SUB_EN adds the 'sub' request bit.
interface param_chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PARAM_CHUNK_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;
    logic             done;

    // Requester side: issues operations and observes results.
    modport master (
        output start, a, b, cin,
`ifdef PARAM_CHUNK_ADDER_SUB_EN
        output sub,
`endif
        input  sum, carry, busy, done
    );

    // Adder side: accepts operations and presents results.
    modport slave (
        input  start, a, b, cin,
`ifdef PARAM_CHUNK_ADDER_SUB_EN
        input  sub,
`endif
        output sum, carry, busy, done
    );
endinterface

// File: rtl/param_chunk_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock with a
// registered carry rippling between chunks. Result is published once per
// operation and held until the next one completes.
// Optional macro PARAM_CHUNK_ADDER_SUB_EN enables subtraction (a - b) via bus.sub.
module param_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    param_chunk_adder_if.slave   bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    // Operands must split into whole chunks; refuse to elaborate otherwise.
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("param_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry_q;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  shadow;
    logic [WIDTH-1:0]  shadow_next;
    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_out;
    logic              busy_o;
    logic              done_o;
    logic              do_sub;
    logic              accept;
    logic              last_chunk;

`ifdef PARAM_CHUNK_ADDER_SUB_EN
    assign do_sub = bus.sub;
`else
    assign do_sub = 1'b0;
`endif

    // A new request is taken whenever no operation is in flight (IDLE or DONE).
    assign accept     = bus.start && (state != RUN);
    assign last_chunk = (idx == IDXW'(N - 1));

    assign bus.sum   = sum_q;
    assign bus.carry = carry_out;
    assign bus.busy  = busy_o;
    assign bus.done  = done_o;

    // Add the current chunk and merge it into the shadow result.
    always_comb begin
        chunk_sum = {1'b0, op_a[idx*CHUNK +: CHUNK]}
                  + {1'b0, op_b[idx*CHUNK +: CHUNK]}
                  + (CHUNK+1)'(carry_q);
        shadow_next = shadow;
        shadow_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; DONE accepts a new request just like IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.start ? RUN : IDLE;
            RUN:     state_next = last_chunk ? DONE : RUN;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy_o = (state == RUN);
        done_o = (state == DONE);
    end

    // Datapath: capture operands on accept, ripple chunks while running,
    // publish the result on the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            shadow    <= '0;
            sum_q     <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            op_a    <= bus.a;
            op_b    <= do_sub ? ~bus.b : bus.b;
            carry_q <= do_sub ? 1'b1 : bus.cin;
            idx     <= '0;
        end else if (state == RUN) begin
            shadow  <= shadow_next;
            carry_q <= chunk_sum[CHUNK];
            if (last_chunk) begin
                sum_q     <= shadow_next;
                carry_out <= chunk_sum[CHUNK];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_param_chunk_adder.sv
// Self-checking bench for param_chunk_adder: three configurations
// (8/2, 2/1 and the single-chunk 4/4), directed and random operations
// compared against an arithmetic reference model.
module tb_param_chunk_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   sel    = 0;

    always #5 clk = ~clk;

    param_chunk_adder_if #(.WIDTH(8)) bus8();
    param_chunk_adder_if #(.WIDTH(2)) bus2();
    param_chunk_adder_if #(.WIDTH(4)) bus4();

    param_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    param_chunk_adder #(.WIDTH(2), .CHUNK(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    param_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [7:0] cur_sum;
    logic       cur_carry;
    logic       cur_busy;
    logic       cur_done;

    // Observe the instance currently under test.
    always_comb begin
        cur_sum   = 8'h00;
        cur_carry = 1'b0;
        cur_busy  = 1'b0;
        cur_done  = 1'b0;
        case (sel)
            0: begin cur_sum = bus8.sum;       cur_carry = bus8.carry; cur_busy = bus8.busy; cur_done = bus8.done; end
            1: begin cur_sum = {6'h0, bus2.sum}; cur_carry = bus2.carry; cur_busy = bus2.busy; cur_done = bus2.done; end
            default: begin cur_sum = {4'h0, bus4.sum}; cur_carry = bus4.carry; cur_busy = bus4.busy; cur_done = bus4.done; end
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 2 : 4;
    endfunction

    function automatic int cycles_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 2 : 1;
    endfunction

    // Reference: {carry,sum} = a + b + cin, or a - b (carry = no borrow).
    function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
        int unsigned ua;
        int unsigned ub;
        int unsigned total;
        int unsigned mask;
        mask = (32'd1 << w) - 1;
        ua = 32'(a) & mask;
        ub = 32'(b) & mask;
        if (sb) total = (32'd1 << w) + ua - ub;
        else    total = ua + ub + 32'(ci);
        return {1'(total >> w), 8'(total & mask)};
    endfunction

    task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb);
        case (sel)
            0: begin bus8.start = st; bus8.a = a;      bus8.b = b;      bus8.cin = ci; end
            1: begin bus2.start = st; bus2.a = a[1:0]; bus2.b = b[1:0]; bus2.cin = ci; end
            default: begin bus4.start = st; bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.cin = ci; end
        endcase
`ifdef PARAM_CHUNK_ADDER_SUB_EN
        case (sel)
            0: bus8.sub = sb;
            1: bus2.sub = sb;
            default: bus4.sub = sb;
        endcase
`endif
    endtask

    // One full operation; 'scramble' wiggles inputs (and start) while busy.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, input bit scramble);
        logic [8:0] exp;
        int         n;
        int         cycles;
        n   = cycles_of(sel);
        exp = model(width_of(sel), a, b, ci, sb);
        @(negedge clk);
        drive(1'b1, a, b, ci, sb);
        @(negedge clk);
        if (scramble) drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else          drive(1'b0, a, b, ci, sb);
        checks++;
        if (cur_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s busy_after_start: got %b want 1", name, cur_busy);
        end
        cycles = 0;
        while (cur_done !== 1'b1 && cycles < 4 * n + 4) begin
            @(negedge clk);
            cycles++;
            if (scramble && cur_busy === 1'b1)
                drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                drive(1'b0, a, b, ci, sb);
        end
        checks++;
        if (cycles != n) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d want %0d", name, cycles, n);
        end
        checks++;
        if ({cur_carry, cur_sum} !== exp) begin
            errors++;
            $display("[TB] FAIL %s result: got carry=%b sum=%h want carry=%b sum=%h",
                     name, cur_carry, cur_sum, exp[8], exp[7:0]);
        end
        checks++;
        if (cur_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s busy_at_done: got %b want 0", name, cur_busy);
        end
        @(negedge clk);
        checks++;
        if (cur_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done_width: got %b want 0", name, cur_done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({cur_carry, cur_sum, cur_busy, cur_done} !== 11'b0) begin
                errors++;
                $display("[TB] FAIL reset_state[%0d]: got c=%b s=%h busy=%b done=%b want zeros",
                         s, cur_carry, cur_sum, cur_busy, cur_done);
            end
        end
        rst = 1'b0;
        sel = 0;
    endtask

    task automatic test_directed;
        sel = 0;
        run_op("add_3C_0F", 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
        run_op("add_FF_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
`ifdef PARAM_CHUNK_ADDER_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_back_to_back;
        int cycles;
        sel = 0;
        @(negedge clk);
        drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h7F, 8'h80, 1'b1, 1'b0);
        cycles = 0;
        while (cur_done !== 1'b1 && cycles < 20) begin @(negedge clk); cycles++; end
        checks++;
        if ({cur_done, cur_carry, cur_sum} !== {1'b1, 9'h100}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got done=%b c=%b s=%h want done=1 c=1 s=00",
                     cur_done, cur_carry, cur_sum);
        end
        @(negedge clk);
        drive(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
        checks++;
        if ({cur_busy, cur_done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_restart: got busy=%b done=%b want busy=1 done=0", cur_busy, cur_done);
        end
        cycles = 0;
        while (cur_done !== 1'b1 && cycles < 20) begin @(negedge clk); cycles++; end
        checks++;
        if ({cur_done, cur_carry, cur_sum} !== {1'b1, 9'h100}) begin
            errors++;
            $display("[TB] FAIL b2b_second: got done=%b c=%b s=%h want done=1 c=1 s=00",
                     cur_done, cur_carry, cur_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int dones;
        sel = 0;
        @(negedge clk);
        drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'hAA, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'hAA, 8'h01, 1'b0, 1'b0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cur_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL busy_start_dones: got %0d want 1", dones);
        end
        checks++;
        if ({cur_carry, cur_sum} !== 9'h002) begin
            errors++;
            $display("[TB] FAIL busy_start_result: got c=%b s=%h want c=0 s=02", cur_carry, cur_sum);
        end
    endtask

    task automatic test_reset_mid_run;
        int dones;
        sel = 0;
        @(negedge clk);
        drive(1'b1, 8'h55, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h55, 8'h55, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({cur_carry, cur_sum, cur_busy, cur_done} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: got c=%b s=%h busy=%b done=%b want zeros",
                     cur_carry, cur_sum, cur_busy, cur_done);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cur_done === 1'b1 || cur_busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_activity: got %0d active cycles want 0", dones);
        end
        run_op("after_reset_55_55", 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_width2_table;
        logic [7:0] ta [8] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
        logic [7:0] tb [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
        sel = 1;
        for (int i = 0; i < 8; i++)
            run_op($sformatf("w2_table_%0d", i), ta[i], tb[i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic sb;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int i = 0; i < 25; i++) begin
`ifdef PARAM_CHUNK_ADDER_SUB_EN
                sb = 1'($urandom_range(0, 1));
`else
                sb = 1'b0;
`endif
                run_op($sformatf("rand_%0d_%0d", s, i), 8'($urandom), 8'($urandom),
                       1'($urandom_range(0, 1)), sb, 1'b1);
            end
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_run();
        test_width2_table();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
